// File: rtl/ysyx_23060025_lsu_if.sv
// ---------------------------------------------------------------------------
// ysyx_23060025_lsu_if
// Memory-side bus between the load/store unit and its memory. The signal
// names are written from the LSU's point of view: t_* leave the LSU and
// f_* arrive at it.
//
// Signals:
//   t_mem_req_valid_o   request valid
//   f_mem_req_ready_i   memory accepts request
//   t_mem_addr_o        word-aligned request address
//   t_mem_wen_o         1 = write, 0 = read
//   t_mem_wdata_o       lane-shifted store data
//   t_mem_wstrb_o       byte strobes (0 on reads)
//   f_mem_resp_valid_i  response valid
//   t_mem_resp_ready_o  LSU accepts response
//   f_mem_rdata_i       read data
//   f_mem_resp_err_i    access error
//
// Modports: master (LSU side), slave (memory side).
// ---------------------------------------------------------------------------
interface ysyx_23060025_lsu_if;
   logic        t_mem_req_valid_o;
   logic        f_mem_req_ready_i;
   logic [31:0] t_mem_addr_o;
   logic        t_mem_wen_o;
   logic [31:0] t_mem_wdata_o;
   logic [3:0]  t_mem_wstrb_o;
   logic        f_mem_resp_valid_i;
   logic        t_mem_resp_ready_o;
   logic [31:0] f_mem_rdata_i;
   logic        f_mem_resp_err_i;

   modport master (
      output t_mem_req_valid_o, t_mem_addr_o, t_mem_wen_o, t_mem_wdata_o,
             t_mem_wstrb_o, t_mem_resp_ready_o,
      input  f_mem_req_ready_i, f_mem_resp_valid_i, f_mem_rdata_i, f_mem_resp_err_i
   );

   modport slave (
      input  t_mem_req_valid_o, t_mem_addr_o, t_mem_wen_o, t_mem_wdata_o,
             t_mem_wstrb_o, t_mem_resp_ready_o,
      output f_mem_req_ready_i, f_mem_resp_valid_i, f_mem_rdata_i, f_mem_resp_err_i
   );
endinterface

// File: rtl/ysyx_23060025_lsu.sv
// ---------------------------------------------------------------------------
// ysyx_23060025_lsu
// Load/store unit sitting behind the EX->LSU pipeline register. Accepts one
// instruction per handshake, issues at most one memory request, aligns store
// lanes / extracts load data, and hands the result to WBU.
//
// Ports:
//   clock, reset               clock and asynchronous active-low reset
//   f_ex_lsu_valid_i / t_lsu_ready_o   EX->LSU handshake
//   f_* payload                EX->LSU register contents
//   mem                        memory bus (ysyx_23060025_lsu_if.master)
//   t_wbu_valid_o / f_wbu_ready_i      LSU->WBU handshake
//   t_wbu_* payload            result to WBU, incl. access fault flag
//
// Optional feature: define YSYX_23060025_LSU_MISALIGN_CHECK_EN to turn
// misaligned LH/LHU/SH/LW/SW into an immediate access fault with no memory
// request. Without it, misaligned accesses go to memory with shifted lanes.
// ---------------------------------------------------------------------------
module ysyx_23060025_lsu #(
   parameter int DATA_WIDTH = 32
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  f_ex_lsu_valid_i,
   output logic                  t_lsu_ready_o,
   input  logic                  f_wd_i,
   input  logic [4:0]            f_wreg_i,
   input  logic [DATA_WIDTH-1:0] f_alu_result_i,
   input  logic                  f_mem_wen_i,
   input  logic [DATA_WIDTH-1:0] f_mem_wdata_i,
   input  logic [2:0]            f_load_type_i,
   input  logic [1:0]            f_store_type_i,
   input  logic [DATA_WIDTH-1:0] f_csr_wdata_i,
   input  logic [2:0]            f_csr_type_i,
   input  logic                  f_ebreak_flag_i,
   ysyx_23060025_lsu_if.master   mem,
   output logic                  t_wbu_valid_o,
   input  logic                  f_wbu_ready_i,
   output logic                  t_wbu_wd_o,
   output logic [4:0]            t_wbu_wreg_o,
   output logic [DATA_WIDTH-1:0] t_wbu_wdata_o,
   output logic [DATA_WIDTH-1:0] t_wbu_csr_wdata_o,
   output logic [2:0]            t_wbu_csr_type_o,
   output logic                  t_wbu_ebreak_flag_o,
   output logic                  t_wbu_access_fault_o
);

   localparam logic [2:0] LT_LB  = 3'b001;
   localparam logic [2:0] LT_LH  = 3'b010;
   localparam logic [2:0] LT_LW  = 3'b011;
   localparam logic [2:0] LT_LBU = 3'b100;
   localparam logic [2:0] LT_LHU = 3'b101;
   localparam logic [1:0] ST_SB  = 2'b01;
   localparam logic [1:0] ST_SH  = 2'b10;
   localparam logic [1:0] ST_SW  = 2'b11;

   typedef enum logic [1:0] {ST_IDLE, ST_REQ, ST_WAIT, ST_DONE} lsuState_e;

   lsuState_e        r_state;
   logic             r_lsuReady, r_reqValid, r_respReady, r_wbuValid;
   logic             r_wd, r_memWen, r_ebreak, r_fault;
   logic [4:0]       r_wreg;
   logic [2:0]       r_loadType, r_csrType;
   logic [1:0]       r_storeType;
   logic [31:0]      r_aluResult, r_memWdata, r_csrWdata, r_rdata;

   logic             w_inIsLoad, w_inIsMem, w_isLoad, w_earlyFault;
   logic [1:0]       w_off;
   logic [3:0]       w_wstrb;
   logic [31:0]      w_loadShift, w_loadData;

   // A load is any recognised load type with the write enable low; unknown
   // load types (110/111) behave like ordinary ALU instructions.
   assign w_inIsLoad = !f_mem_wen_i && (f_load_type_i >= LT_LB) && (f_load_type_i <= LT_LHU);
   assign w_inIsMem  = f_mem_wen_i || w_inIsLoad;
   assign w_isLoad   = !r_memWen && (r_loadType >= LT_LB) && (r_loadType <= LT_LHU);
   assign w_off      = r_aluResult[1:0];

`ifdef YSYX_23060025_LSU_MISALIGN_CHECK_EN
   logic       w_misaligned;
   logic [1:0] w_inOff;
   assign w_inOff = f_alu_result_i[1:0];

   // Halfwords need an even offset and words a zero offset; bytes never fault.
   always_comb begin
      w_misaligned = 1'b0;
      if (f_mem_wen_i) begin
         case (f_store_type_i)
            ST_SH:   w_misaligned = w_inOff[0];
            ST_SW:   w_misaligned = (w_inOff != 2'b00);
            default: w_misaligned = 1'b0;
         endcase
      end else begin
         case (f_load_type_i)
            LT_LH, LT_LHU: w_misaligned = w_inOff[0];
            LT_LW:         w_misaligned = (w_inOff != 2'b00);
            default:       w_misaligned = 1'b0;
         endcase
      end
   end
   assign w_earlyFault = w_inIsMem && w_misaligned;
`else
   assign w_earlyFault = 1'b0;
`endif

   // Byte strobes follow the store size shifted to the byte offset; bits
   // pushed past lane 3 simply fall off. Reads never assert strobes.
   always_comb begin
      w_wstrb = 4'b0000;
      if (r_memWen) begin
         case (r_storeType)
            ST_SB:   w_wstrb = 4'b0001 << w_off;
            ST_SH:   w_wstrb = 4'b0011 << w_off;
            ST_SW:   w_wstrb = 4'b1111;
            default: w_wstrb = 4'b0000;
         endcase
      end
   end

   // Load data is shifted down with zero fill first, so a halfword at offset
   // 3 sees a zero upper byte before extension.
   assign w_loadShift = r_rdata >> {w_off, 3'b000};
   always_comb begin
      w_loadData = w_loadShift;
      case (r_loadType)
         LT_LB:   w_loadData = {{24{w_loadShift[7]}}, w_loadShift[7:0]};
         LT_LH:   w_loadData = {{16{w_loadShift[15]}}, w_loadShift[15:0]};
         LT_LBU:  w_loadData = {24'h000000, w_loadShift[7:0]};
         LT_LHU:  w_loadData = {16'h0000, w_loadShift[15:0]};
         default: w_loadData = w_loadShift;
      endcase
   end

   // Main sequencer. Handshake outputs are registered alongside the state so
   // each one is a clean flop; a reset anywhere drops any outstanding request.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_state     <= ST_IDLE;
         r_lsuReady  <= 1'b0;
         r_reqValid  <= 1'b0;
         r_respReady <= 1'b0;
         r_wbuValid  <= 1'b0;
         r_wd        <= 1'b0;
         r_wreg      <= 5'd0;
         r_aluResult <= 32'd0;
         r_memWen    <= 1'b0;
         r_memWdata  <= 32'd0;
         r_loadType  <= 3'd0;
         r_storeType <= 2'd0;
         r_csrWdata  <= 32'd0;
         r_csrType   <= 3'd0;
         r_ebreak    <= 1'b0;
         r_rdata     <= 32'd0;
         r_fault     <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               r_lsuReady <= 1'b1;
               if (f_ex_lsu_valid_i && r_lsuReady) begin
                  r_wd        <= f_wd_i;
                  r_wreg      <= f_wreg_i;
                  r_aluResult <= f_alu_result_i;
                  r_memWen    <= f_mem_wen_i;
                  r_memWdata  <= f_mem_wdata_i;
                  r_loadType  <= f_load_type_i;
                  r_storeType <= f_store_type_i;
                  r_csrWdata  <= f_csr_wdata_i;
                  r_csrType   <= f_csr_type_i;
                  r_ebreak    <= f_ebreak_flag_i;
                  r_rdata     <= 32'd0;
                  r_fault     <= w_earlyFault;
                  r_lsuReady  <= 1'b0;
                  if (w_inIsMem && !w_earlyFault) begin
                     r_reqValid <= 1'b1;
                     r_state    <= ST_REQ;
                  end else begin
                     r_wbuValid <= 1'b1;
                     r_state    <= ST_DONE;
                  end
               end
            end
            ST_REQ: begin
               if (mem.f_mem_req_ready_i) begin
                  r_reqValid  <= 1'b0;
                  r_respReady <= 1'b1;
                  r_state     <= ST_WAIT;
               end
            end
            ST_WAIT: begin
               if (mem.f_mem_resp_valid_i) begin
                  r_rdata     <= mem.f_mem_rdata_i;
                  r_fault     <= mem.f_mem_resp_err_i;
                  r_respReady <= 1'b0;
                  r_wbuValid  <= 1'b1;
                  r_state     <= ST_DONE;
               end
            end
            ST_DONE: begin
               if (f_wbu_ready_i) begin
                  r_wbuValid <= 1'b0;
                  r_lsuReady <= 1'b1;
                  r_state    <= ST_IDLE;
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign t_lsu_ready_o          = r_lsuReady;
   assign mem.t_mem_req_valid_o  = r_reqValid;
   assign mem.t_mem_addr_o       = {r_aluResult[31:2], 2'b00};
   assign mem.t_mem_wen_o        = r_memWen;
   assign mem.t_mem_wdata_o      = r_memWdata << {w_off, 3'b000};
   assign mem.t_mem_wstrb_o      = w_wstrb;
   assign mem.t_mem_resp_ready_o = r_respReady;

   assign t_wbu_valid_o        = r_wbuValid;
   assign t_wbu_wd_o           = r_wd && !r_fault;
   assign t_wbu_wreg_o         = r_wreg;
   assign t_wbu_wdata_o        = w_isLoad ? w_loadData : r_aluResult;
   assign t_wbu_csr_wdata_o    = r_csrWdata;
   assign t_wbu_csr_type_o     = r_csrType;
   assign t_wbu_ebreak_flag_o  = r_ebreak;
   assign t_wbu_access_fault_o = r_fault;

endmodule

// File: tb/tb_ysyx_23060025_lsu.sv
// ---------------------------------------------------------------------------
// tb_ysyx_23060025_lsu
// Self-checking bench for the LSU. The bench plays both EX and memory/WBU,
// and predicts every output from a byte-lane model of the load/store rules.
// ---------------------------------------------------------------------------
module tb_ysyx_23060025_lsu;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic        f_ex_lsu_valid_i = 1'b0;
   logic        t_lsu_ready_o;
   logic        f_wd_i = 1'b0;
   logic [4:0]  f_wreg_i = 5'd0;
   logic [31:0] f_alu_result_i = 32'd0;
   logic        f_mem_wen_i = 1'b0;
   logic [31:0] f_mem_wdata_i = 32'd0;
   logic [2:0]  f_load_type_i = 3'd0;
   logic [1:0]  f_store_type_i = 2'd0;
   logic [31:0] f_csr_wdata_i = 32'd0;
   logic [2:0]  f_csr_type_i = 3'd0;
   logic        f_ebreak_flag_i = 1'b0;
   logic        t_wbu_valid_o;
   logic        f_wbu_ready_i = 1'b0;
   logic        t_wbu_wd_o;
   logic [4:0]  t_wbu_wreg_o;
   logic [31:0] t_wbu_wdata_o;
   logic [31:0] t_wbu_csr_wdata_o;
   logic [2:0]  t_wbu_csr_type_o;
   logic        t_wbu_ebreak_flag_o;
   logic        t_wbu_access_fault_o;

   int compared = 0;
   int mismatched = 0;

`ifdef YSYX_23060025_LSU_MISALIGN_CHECK_EN
   localparam bit MISALIGN_EN = 1'b1;
`else
   localparam bit MISALIGN_EN = 1'b0;
`endif

   ysyx_23060025_lsu_if memBus ();

   ysyx_23060025_lsu #(.DATA_WIDTH(32)) dut (
      .clock                (clock),
      .reset                (reset),
      .f_ex_lsu_valid_i     (f_ex_lsu_valid_i),
      .t_lsu_ready_o        (t_lsu_ready_o),
      .f_wd_i               (f_wd_i),
      .f_wreg_i             (f_wreg_i),
      .f_alu_result_i       (f_alu_result_i),
      .f_mem_wen_i          (f_mem_wen_i),
      .f_mem_wdata_i        (f_mem_wdata_i),
      .f_load_type_i        (f_load_type_i),
      .f_store_type_i       (f_store_type_i),
      .f_csr_wdata_i        (f_csr_wdata_i),
      .f_csr_type_i         (f_csr_type_i),
      .f_ebreak_flag_i      (f_ebreak_flag_i),
      .mem                  (memBus.master),
      .t_wbu_valid_o        (t_wbu_valid_o),
      .f_wbu_ready_i        (f_wbu_ready_i),
      .t_wbu_wd_o           (t_wbu_wd_o),
      .t_wbu_wreg_o         (t_wbu_wreg_o),
      .t_wbu_wdata_o        (t_wbu_wdata_o),
      .t_wbu_csr_wdata_o    (t_wbu_csr_wdata_o),
      .t_wbu_csr_type_o     (t_wbu_csr_type_o),
      .t_wbu_ebreak_flag_o  (t_wbu_ebreak_flag_o),
      .t_wbu_access_fault_o (t_wbu_access_fault_o)
   );

   // Free-running 10-unit clock.
   always #5 clock = ~clock;

   // Hard stop in case the sequence ever stalls.
   initial begin
      #200000;
      $display("[TB] FAIL watchdog expired before the sequence completed");
      $fatal(1, "[TB] watchdog");
   end

   // Reference model: loads read byte lanes starting at the offset, lanes past
   // byte 3 read as zero, then the selected width is sign/zero extended.
   function automatic logic [31:0] modelLoad(input logic [2:0] lt, input logic [31:0] rdata, input int off);
      longint v;
      longint lane[4];
      logic [63:0] bits;
      for (int k = 0; k < 4; k++)
         lane[k] = (off + k < 4) ? longint'((rdata >> (8 * (off + k))) & 32'hFF) : 64'sd0;
      case (lt)
         3'd1: begin v = lane[0]; if (v >= 128) v = v - 256; end
         3'd2: begin v = lane[0] + 256 * lane[1]; if (v >= 32768) v = v - 65536; end
         3'd4: v = lane[0];
         3'd5: v = lane[0] + 256 * lane[1];
         default: v = lane[0] + 256 * lane[1] + 65536 * lane[2] + 16777216 * lane[3];
      endcase
      bits = 64'(v);
      return bits[31:0];
   endfunction

   // Store data byte k comes from source byte k-off; lower lanes are zero.
   function automatic logic [31:0] modelStoreData(input logic [31:0] sdata, input int off);
      logic [31:0] r;
      r = 32'd0;
      for (int k = 0; k < 4; k++)
         if (k >= off) r[8*k +: 8] = sdata[8*(k-off) +: 8];
      return r;
   endfunction

   // Strobe lane k is on when it lies inside [off, off+size); SW covers all.
   function automatic logic [3:0] modelStrb(input logic wen, input logic [1:0] st, input int off);
      logic [3:0] r;
      int size;
      r = 4'd0;
      if (!wen) return r;
      if (st == 2'd3) return 4'hF;
      size = (st == 2'd1) ? 1 : (st == 2'd2) ? 2 : 0;
      for (int k = 0; k < 4; k++)
         if (k >= off && k < off + size) r[k] = 1'b1;
      return r;
   endfunction

   function automatic bit modelMisaligned(input logic wen, input logic [2:0] lt, input logic [1:0] st, input int off);
      if (wen) return (st == 2'd2 && (off % 2) != 0) || (st == 2'd3 && off != 0);
      return ((lt == 3'd2 || lt == 3'd5) && (off % 2) != 0) || (lt == 3'd3 && off != 0);
   endfunction

   function automatic logic [31:0] z(input logic b);
      return {31'd0, b};
   endfunction

   // One comparison: counted, and reported with $error when it disagrees.
   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      compared++;
      assert (observed === expected) else begin
         mismatched++;
         $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
      end
   endtask

   // Wait (bounded) for the LSU to offer ready at a falling edge.
   task automatic waitReady(input string tag);
      int n;
      n = 0;
      while (t_lsu_ready_o !== 1'b1 && n < 20) begin
         @(negedge clock);
         n++;
      end
      checkOutput(tag, z(t_lsu_ready_o), 32'd1);
   endtask

   // Run one complete instruction through the LSU, acting as EX, memory and
   // WBU, and check every observable step. Entered and left at a falling edge.
   task automatic applyStimulus(input string name, input logic wen, input logic [2:0] lt,
                                input logic [1:0] st, input logic [31:0] alu, input logic [31:0] sdata,
                                input logic [31:0] rdata, input logic err,
                                input int reqWait, input int respWait, input int wbuWait);
      logic        wd;
      logic [4:0]  wreg;
      logic [31:0] csrW;
      logic [2:0]  csrT;
      logic        ebr;
      int          off;
      bit          isLoad, isMem, early, expFault;
      logic [31:0] expWbu;

      wd   = 1'($urandom);
      wreg = 5'($urandom);
      csrW = $urandom;
      csrT = 3'($urandom);
      ebr  = 1'($urandom);
      off  = int'(alu[1:0]);
      isLoad = !wen && lt >= 3'd1 && lt <= 3'd5;
      isMem  = wen || isLoad;
      early  = MISALIGN_EN && isMem && modelMisaligned(wen, lt, st, off);
      expFault = early ? 1'b1 : (isMem ? err : 1'b0);
      expWbu = isLoad ? modelLoad(lt, rdata, off) : alu;

      f_ex_lsu_valid_i = 1'b1;
      f_wd_i = wd; f_wreg_i = wreg; f_alu_result_i = alu; f_mem_wen_i = wen;
      f_mem_wdata_i = sdata; f_load_type_i = lt; f_store_type_i = st;
      f_csr_wdata_i = csrW; f_csr_type_i = csrT; f_ebreak_flag_i = ebr;
      waitReady({name, "/acceptReady"});
      @(negedge clock);
      f_ex_lsu_valid_i = 1'b0;

      if (isMem && !early) begin
         checkOutput({name, "/reqValid"}, z(memBus.t_mem_req_valid_o), 32'd1);
         checkOutput({name, "/lsuReadyReq"}, z(t_lsu_ready_o), 32'd0);
         checkOutput({name, "/addr"}, memBus.t_mem_addr_o, alu - 32'(off));
         checkOutput({name, "/wen"}, z(memBus.t_mem_wen_o), z(wen));
         checkOutput({name, "/wstrb"}, {28'd0, memBus.t_mem_wstrb_o}, {28'd0, modelStrb(wen, st, off)});
         if (wen) checkOutput({name, "/memWdata"}, memBus.t_mem_wdata_o, modelStoreData(sdata, off));
         // Stall the request; a stray response meanwhile must be ignored.
         for (int i = 0; i < reqWait; i++) begin
            memBus.f_mem_resp_valid_i = 1'b1;
            memBus.f_mem_rdata_i = ~rdata;
            memBus.f_mem_resp_err_i = 1'b1;
            @(negedge clock);
            checkOutput({name, "/reqHeld"}, z(memBus.t_mem_req_valid_o), 32'd1);
            checkOutput({name, "/addrHeld"}, memBus.t_mem_addr_o, alu - 32'(off));
            checkOutput({name, "/respReadyInReq"}, z(memBus.t_mem_resp_ready_o), 32'd0);
            checkOutput({name, "/lsuReadyHeld"}, z(t_lsu_ready_o), 32'd0);
         end
         memBus.f_mem_resp_valid_i = 1'b0;
         memBus.f_mem_resp_err_i = 1'b0;
         memBus.f_mem_req_ready_i = 1'b1;
         @(negedge clock);
         memBus.f_mem_req_ready_i = 1'b0;
         checkOutput({name, "/respReady"}, z(memBus.t_mem_resp_ready_o), 32'd1);
         checkOutput({name, "/reqDropped"}, z(memBus.t_mem_req_valid_o), 32'd0);
         for (int i = 0; i < respWait; i++) begin
            @(negedge clock);
            checkOutput({name, "/waitHeld"}, z(t_wbu_valid_o), 32'd0);
         end
         memBus.f_mem_resp_valid_i = 1'b1;
         memBus.f_mem_rdata_i = rdata;
         memBus.f_mem_resp_err_i = err;
         @(negedge clock);
         memBus.f_mem_resp_valid_i = 1'b0;
         memBus.f_mem_resp_err_i = 1'b0;
      end else begin
         checkOutput({name, "/noReq"}, z(memBus.t_mem_req_valid_o), 32'd0);
      end

      checkOutput({name, "/wbuValid"}, z(t_wbu_valid_o), 32'd1);
      checkOutput({name, "/fault"}, z(t_wbu_access_fault_o), z(expFault));
      checkOutput({name, "/wd"}, z(t_wbu_wd_o), z(expFault ? 1'b0 : wd));
      checkOutput({name, "/wreg"}, {27'd0, t_wbu_wreg_o}, {27'd0, wreg});
      if (!(early && isLoad)) checkOutput({name, "/wbuWdata"}, t_wbu_wdata_o, expWbu);
      checkOutput({name, "/csrWdata"}, t_wbu_csr_wdata_o, csrW);
      checkOutput({name, "/csrType"}, {29'd0, t_wbu_csr_type_o}, {29'd0, csrT});
      checkOutput({name, "/ebreak"}, z(t_wbu_ebreak_flag_o), z(ebr));
      checkOutput({name, "/lsuReadyDone"}, z(t_lsu_ready_o), 32'd0);
      for (int i = 0; i < wbuWait; i++) begin
         @(negedge clock);
         checkOutput({name, "/wbuHeld"}, z(t_wbu_valid_o), 32'd1);
         checkOutput({name, "/faultHeld"}, z(t_wbu_access_fault_o), z(expFault));
         if (!(early && isLoad)) checkOutput({name, "/wdataHeld"}, t_wbu_wdata_o, expWbu);
      end
      f_wbu_ready_i = 1'b1;
      @(negedge clock);
      f_wbu_ready_i = 1'b0;
      checkOutput({name, "/wbuReleased"}, z(t_wbu_valid_o), 32'd0);
      checkOutput({name, "/readyAgain"}, z(t_lsu_ready_o), 32'd1);
   endtask

   initial begin
      memBus.f_mem_req_ready_i  = 1'b0;
      memBus.f_mem_resp_valid_i = 1'b0;
      memBus.f_mem_rdata_i      = 32'd0;
      memBus.f_mem_resp_err_i   = 1'b0;

      // Reset: every output low while held.
      #2 reset = 1'b0;
      @(negedge clock);
      checkOutput("rst/lsuReady", z(t_lsu_ready_o), 32'd0);
      checkOutput("rst/wbuValid", z(t_wbu_valid_o), 32'd0);
      checkOutput("rst/reqValid", z(memBus.t_mem_req_valid_o), 32'd0);
      checkOutput("rst/respReady", z(memBus.t_mem_resp_ready_o), 32'd0);
      checkOutput("rst/addr", memBus.t_mem_addr_o, 32'd0);
      checkOutput("rst/wstrb", {28'd0, memBus.t_mem_wstrb_o}, 32'd0);
      checkOutput("rst/wbuWdata", t_wbu_wdata_o, 32'd0);
      checkOutput("rst/fault", z(t_wbu_access_fault_o), 32'd0);
      reset = 1'b1;
      waitReady("rst/readyAfter");

      // Directed cases.
      applyStimulus("add", 1'b0, 3'd0, 2'd0, 32'h0000_1234, 32'd0, 32'd0, 1'b0, 0, 0, 0);
      applyStimulus("lb",  1'b0, 3'd1, 2'd0, 32'h8000_0003, 32'd0, 32'h80FF_0000, 1'b0, 0, 0, 0);
      applyStimulus("lbu", 1'b0, 3'd4, 2'd0, 32'h8000_0003, 32'd0, 32'h80FF_0000, 1'b0, 0, 0, 0);
      applyStimulus("sh",  1'b1, 3'd0, 2'd2, 32'h8000_0002, 32'h0000_ABCD, 32'd0, 1'b0, 3, 1, 2);
      applyStimulus("lwErr", 1'b0, 3'd3, 2'd0, 32'h8000_0000, 32'd0, 32'hDEAD_BEEF, 1'b1, 0, 2, 0);
      applyStimulus("lwMis", 1'b0, 3'd3, 2'd0, 32'h8000_0002, 32'd0, 32'h1122_3344, 1'b0, 0, 0, 0);
      applyStimulus("lhOff3", 1'b0, 3'd2, 2'd0, 32'h8000_0007, 32'd0, 32'hF000_0000, 1'b0, 1, 0, 1);

      // Reset in WAIT abandons the load.
      f_ex_lsu_valid_i = 1'b1;
      f_alu_result_i = 32'h8000_0010; f_mem_wen_i = 1'b0; f_load_type_i = 3'd3; f_wd_i = 1'b1;
      waitReady("rstWait/accept");
      @(negedge clock);
      f_ex_lsu_valid_i = 1'b0;
      memBus.f_mem_req_ready_i = 1'b1;
      @(negedge clock);
      memBus.f_mem_req_ready_i = 1'b0;
      checkOutput("rstWait/inWait", z(memBus.t_mem_resp_ready_o), 32'd1);
      reset = 1'b0;
      #1;
      checkOutput("rstWait/respReady", z(memBus.t_mem_resp_ready_o), 32'd0);
      checkOutput("rstWait/lsuReady", z(t_lsu_ready_o), 32'd0);
      checkOutput("rstWait/wbuValid", z(t_wbu_valid_o), 32'd0);
      checkOutput("rstWait/addr", memBus.t_mem_addr_o, 32'd0);
      checkOutput("rstWait/wd", z(t_wbu_wd_o), 32'd0);
      @(negedge clock);
      reset = 1'b1;
      memBus.f_mem_resp_valid_i = 1'b1;
      memBus.f_mem_rdata_i = 32'h5555_AAAA;
      @(negedge clock);
      memBus.f_mem_resp_valid_i = 1'b0;
      checkOutput("rstWait/noWbu", z(t_wbu_valid_o), 32'd0);
      waitReady("rstWait/readyBack");
      checkOutput("rstWait/stillNoWbu", z(t_wbu_valid_o), 32'd0);

      // Randomised instructions against the byte-lane model.
      for (int t = 0; t < 40; t++) begin
         int kind;
         logic [2:0] lt;
         logic [1:0] st;
         logic wen;
         kind = int'($urandom_range(0, 8));
         lt = 3'd0; st = 2'd0; wen = 1'b0;
         if (kind == 0) begin
            case ($urandom_range(0, 2))
               0: lt = 3'd0;
               1: lt = 3'd6;
               default: lt = 3'd7;
            endcase
         end else if (kind <= 5) begin
            lt = 3'(kind);
         end else begin
            wen = 1'b1;
            st = 2'(kind - 5);
            lt = 3'($urandom);
         end
         applyStimulus($sformatf("rnd%0d", t), wen, lt, st, $urandom, $urandom, $urandom,
                       ($urandom_range(0, 7) == 0), int'($urandom_range(0, 3)),
                       int'($urandom_range(0, 3)), int'($urandom_range(0, 2)));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule

// File: doc/ysyx_23060025_lsu.md
# ysyx_23060025_lsu

Load/store unit at the consumer end of the EX→LSU pipeline register. It accepts one instruction per handshake from EX and, for loads and stores, issues a single request on a simple valid/ready memory port. It aligns store data and byte strobes, extracts and extends load data, and hands the result to WBU over a valid/ready handshake. Non-memory instructions pass through in one cycle.

## Interface
- DATA_WIDTH, 32, data and address width (only 32 is supported)
- clock  in  1  single clock; all state changes on its rising edge
- reset  in  1  asynchronous, active-low reset
- f_ex_lsu_valid_i  in  1  EX→LSU payload valid
- t_lsu_ready_o  out  1  LSU can accept; feeds EX's f_lsu_ready_i
- f_wd_i, f_wreg_i[4:0], f_alu_result_i[31:0], f_mem_wen_i, f_mem_wdata_i[31:0], f_load_type_i[2:0], f_store_type_i[1:0], f_csr_wdata_i[31:0], f_csr_type_i[2:0], f_ebreak_flag_i  in  payload from the EX→LSU register
- t_mem_req_valid_o  out  1  memory request valid
- f_mem_req_ready_i  in  1  memory accepts request
- t_mem_addr_o  out  32  request address (word-aligned: addr[1:0] forced to 0)
- t_mem_wen_o  out  1  1 = write, 0 = read
- t_mem_wdata_o  out  32  lane-shifted store data
- t_mem_wstrb_o  out  4  byte strobes (0 on reads)
- f_mem_resp_valid_i  in  1  response valid
- t_mem_resp_ready_o  out  1  LSU accepts response
- f_mem_rdata_i  in  32  read data
- f_mem_resp_err_i  in  1  access error
- t_wbu_valid_o  out  1  result valid to WBU
- f_wbu_ready_i  in  1  WBU accepts
- t_wbu_wd_o, t_wbu_wreg_o[4:0], t_wbu_wdata_o[31:0], t_wbu_csr_wdata_o[31:0], t_wbu_csr_type_o[2:0], t_wbu_ebreak_flag_o  out  result payload
- t_wbu_access_fault_o  out  1  memory error or misaligned access (see Configuration)

## Operation
- Encodings: load_type 000 none, 001 LB, 010 LH, 011 LW, 100 LBU, 101 LHU, others treated as none. store_type 00 none, 01 SB, 10 SH, 11 SW. A store is an instruction with f_mem_wen_i=1. A load is an instruction with load_type≠none and f_mem_wen_i=0.
- FSM states: IDLE, REQ, WAIT, DONE.
  - IDLE: t_lsu_ready_o=1. On valid&ready, latch the full payload. A memory operation goes to REQ; anything else goes to DONE.
  - REQ: t_mem_req_valid_o=1, with address, wen, wdata and wstrb held stable. On f_mem_req_ready_i, go to WAIT.
  - WAIT: t_mem_resp_ready_o=1. On f_mem_resp_valid_i, latch rdata and err, then go to DONE.
  - DONE: t_wbu_valid_o=1, payload held. On f_wbu_ready_i, go to IDLE.
- Store lanes, with off=addr[1:0]:
  - wdata = f_mem_wdata_i << (8·off)
  - wstrb = SB 4'b0001<<off, SH 4'b0011<<off, SW 4'b1111, truncated to 4 bits
- Load data: r = rdata >> (8·off).
  - LB/LH sign-extend r[7:0]/r[15:0]; LBU/LHU zero-extend; LW passes r.
  - The shift fills with zeros, so LH at off=3 yields sign-extension of {8'h00, byte3}.
- t_wbu_wdata_o: extended load data for loads, latched alu_result otherwise (stores and non-memory).
- On error: t_wbu_access_fault_o=1 and t_wbu_wd_o forced 0. The remaining payload passes unchanged.

## Timing
- Reset (async, reset=0): state IDLE, all latched payload 0. Every output is 0 except t_lsu_ready_o, which is 1 after reset deassert.
- Reset asserted mid-transaction abandons any outstanding request or response. After reset, no WBU output is produced for it.
- Non-memory latency: accept at edge N, t_wbu_valid_o=1 in cycle N+1.
- Memory latency with zero-wait memory: accept at edge N, req_valid in cycle N+1, WAIT in N+2. A response in N+2 gives t_wbu_valid_o in N+3.
- Each added memory wait cycle adds one cycle.
- A response arriving in REQ is ignored because resp_ready=0.
- Throughput is one instruction per DONE→IDLE round trip; t_lsu_ready_o=0 in REQ, WAIT and DONE.
- WBU backpressure holds DONE indefinitely with all outputs stable.

## Configuration
- YSYX_23060025_LSU_MISALIGN_CHECK_EN defined: a misaligned access is one where LH/LHU/SH has off[0]=1, or LW/SW has off≠0.
  - IDLE goes straight to DONE with no memory request.
  - t_wbu_access_fault_o=1 and t_wbu_wd_o=0.
- Not defined: no check; the request is issued with shifted lanes as above, and the fault flag comes only from f_mem_resp_err_i.

## Test plan
- ADD passthrough: alu_result=0x1234, wd=1, wreg=5 → t_wbu_valid_o one cycle after accept, wdata=0x1234, no mem request.
- LB: addr 0x8000_0003, rdata=0x80FF_0000 → mem addr 0x8000_0000, wstrb 0, wdata=0xFFFF_FF80. The same case with LBU → 0x0000_0080.
- SH: addr 0x8000_0002, data 0xABCD → wdata=0xABCD_0000, wstrb=4'b1100, wen=1, WBU wdata=alu_result.
- Backpressure: hold f_mem_req_ready_i=0 for 3 cycles, then f_wbu_ready_i=0 for 2 cycles → req_valid is held with stable addr/data, t_lsu_ready_o=0 throughout, and outputs stay stable in DONE.
- LW with f_mem_resp_err_i=1 → access_fault=1, wd=0. Separately, assert reset during WAIT → all outputs 0 and ready returns to 1 after deassert.
- With the macro defined, LW at 0x...2 → no req_valid, fault=1 one cycle after accept. Without the macro → request issued.
